// File: rtl/roi_window_gen.sv
// Multi-window ROI reference generator: derives pixel/line coordinates from
// vsync/hsync and emits per-window href/vref/act strobes against frame-shadowed bounds.
module roi_window_gen #(
  parameter int CNT_W    = 12,
  parameter int NUM_WIN  = 2,
  parameter int SYNC_POL = 1,
  parameter int FCNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vsync,
  input  logic                     hsync,
  input  logic [NUM_WIN-1:0]       win_en,
  input  logic [NUM_WIN*CNT_W-1:0] win_x0,
  input  logic [NUM_WIN*CNT_W-1:0] win_x1,
  input  logic [NUM_WIN*CNT_W-1:0] win_y0,
  input  logic [NUM_WIN*CNT_W-1:0] win_y1,
  output logic [NUM_WIN-1:0]       win_href,
  output logic [NUM_WIN-1:0]       win_vref,
  output logic [NUM_WIN-1:0]       win_act,
  output logic [CNT_W-1:0]         pix_x,
  output logic [CNT_W-1:0]         line_y,
  output logic                     frame_start,
  output logic                     frame_end,
  output logic [FCNT_W-1:0]        frame_cnt,
  output logic [NUM_WIN-1:0]       cfg_err,
  output logic                     armed
);

  localparam logic [CNT_W-1:0] CMAX = '1;

  logic vs, hs;
  assign vs = (SYNC_POL != 0) ? vsync : ~vsync;
  assign hs = (SYNC_POL != 0) ? hsync : ~hsync;

  logic                     vs_d, hs_d, live, first_line, st_rise, st_fall;
  logic [CNT_W-1:0]         x, y;
  logic [NUM_WIN-1:0]       sh_en;
  logic [NUM_WIN*CNT_W-1:0] sh_x0, sh_x1, sh_y0, sh_y1;
  logic                     vs_rise, vs_fall, hs_rise, arm;

  // live masks the first sample after reset, so a vsync already held active
  // through a mid-frame reset is not mistaken for a new frame start.
  assign vs_rise = live & vs & ~vs_d;
  assign vs_fall = live & ~vs & vs_d;
  assign hs_rise = hs & ~hs_d;
  assign arm     = armed | vs_rise;

  // Stage 1: sync history, coordinates of the pixel sampled on this edge, shadows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live       <= 1'b0;
      vs_d       <= 1'b0;
      hs_d       <= 1'b0;
      armed      <= 1'b0;
      first_line <= 1'b0;
      st_rise    <= 1'b0;
      st_fall    <= 1'b0;
      x          <= '0;
      y          <= '0;
      sh_en      <= '0;
      sh_x0      <= '0;
      sh_x1      <= '0;
      sh_y0      <= '0;
      sh_y1      <= '0;
    end else begin
      live    <= 1'b1;
      vs_d    <= vs;
      hs_d    <= hs;
      st_rise <= vs_rise;
      st_fall <= vs_fall & armed;
      if (vs_rise) begin
        armed <= 1'b1;
        sh_en <= win_en;
        sh_x0 <= win_x0;
        sh_x1 <= win_x1;
        sh_y0 <= win_y0;
        sh_y1 <= win_y1;
      end
      if (!arm || !hs || hs_rise) begin
        x <= '0;
      end else if (x != CMAX) begin
        x <= x + 1'b1;
      end
      if (!arm || !vs) begin
        y          <= '0;
        first_line <= 1'b0;
      end else if (vs_rise) begin
        y          <= '0;
        first_line <= ~hs_rise;
      end else if (hs_rise) begin
        if (first_line) begin
          first_line <= 1'b0;
        end else if (y != CMAX) begin
          y <= y + 1'b1;
        end
      end
    end
  end

  logic [NUM_WIN-1:0] href_n, vref_n, bad;

  always_comb begin
    href_n = '0;
    vref_n = '0;
    bad    = '0;
    for (int unsigned i = 0; i < NUM_WIN; i++) begin
      bad[i] = (sh_x1[i*CNT_W +: CNT_W] < sh_x0[i*CNT_W +: CNT_W]) |
               (sh_y1[i*CNT_W +: CNT_W] < sh_y0[i*CNT_W +: CNT_W]);
      href_n[i] = sh_en[i] & ~bad[i] & armed & hs_d &
                  (x >= sh_x0[i*CNT_W +: CNT_W]) & (x <= sh_x1[i*CNT_W +: CNT_W]);
      vref_n[i] = sh_en[i] & ~bad[i] & armed & vs_d &
                  (y >= sh_y0[i*CNT_W +: CNT_W]) & (y <= sh_y1[i*CNT_W +: CNT_W]);
    end
  end

  // Stage 2: registered outputs, all aligned one edge behind stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_href    <= '0;
      win_vref    <= '0;
      win_act     <= '0;
      pix_x       <= '0;
      line_y      <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_cnt   <= '0;
      cfg_err     <= '0;
    end else begin
      win_href    <= href_n;
      win_vref    <= vref_n;
      win_act     <= href_n & vref_n;
      pix_x       <= x;
      line_y      <= y;
      frame_start <= st_rise;
      frame_end   <= st_fall;
      if (st_fall) frame_cnt <= frame_cnt + 1'b1;
      if (st_rise) cfg_err <= bad;
    end
  end

endmodule

// File: tb/tb_roi_window_gen.sv
// Randomized bench for roi_window_gen: two instances (active-high and active-low syncs)
// checked every cycle against a frame/line/column reference model.
module tb_roi_window_gen;

  localparam int CW   = 12;
  localparam int NW   = 2;
  localparam int FW   = 16;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vsync = 1'b0, hsync = 1'b0;
  logic nvsync, nhsync;
  logic [NW-1:0]    win_en = '0;
  logic [NW*CW-1:0] win_x0 = '0, win_x1 = '0, win_y0 = '0, win_y1 = '0;
  logic [NW-1:0]    alt_en = '0;
  logic [NW*CW-1:0] alt_x0 = '0, alt_x1 = '0, alt_y0 = '0, alt_y1 = '0;

  logic [NW-1:0] a_href, a_vref, a_act, a_err, b_href, b_vref, b_act, b_err;
  logic [CW-1:0] a_x, a_y, b_x, b_y;
  logic          a_fs, a_fe, a_armed, b_fs, b_fe, b_armed;
  logic [FW-1:0] a_fc, b_fc;

  assign nvsync = ~vsync;
  assign nhsync = ~hsync;

  always #5 clk = ~clk;

  roi_window_gen #(.CNT_W(CW), .NUM_WIN(NW), .SYNC_POL(1), .FCNT_W(FW)) dut_a (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .hsync(hsync),
    .win_en(win_en), .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
    .win_href(a_href), .win_vref(a_vref), .win_act(a_act), .pix_x(a_x), .line_y(a_y),
    .frame_start(a_fs), .frame_end(a_fe), .frame_cnt(a_fc), .cfg_err(a_err), .armed(a_armed));

  roi_window_gen #(.CNT_W(CW), .NUM_WIN(NW), .SYNC_POL(0), .FCNT_W(FW)) dut_b (
    .clk(clk), .rst_n(rst_n), .vsync(nvsync), .hsync(nhsync),
    .win_en(win_en), .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
    .win_href(b_href), .win_vref(b_vref), .win_act(b_act), .pix_x(b_x), .line_y(b_y),
    .frame_start(b_fs), .frame_end(b_fe), .frame_cnt(b_fc), .cfg_err(b_err), .armed(b_armed));

  typedef struct {
    logic [NW-1:0] href, vref, act, err;
    int            x, y, fcnt;
    logic          fs, fe;
  } exp_t;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: frame-level view of the sensor stream.
  bit   m_armed, m_live, pv, ph;
  int   m_row, m_col, m_fcnt;
  int   sen[NW], sx0[NW], sx1[NW], sy0[NW], sy1[NW];
  logic [NW-1:0] m_err;
  exp_t e_prev;
  int   act0, act1, fs_b, fe_b;

  function automatic exp_t zero_exp();
    exp_t e;
    e.href = '0; e.vref = '0; e.act = '0; e.err = '0;
    e.x = 0; e.y = 0; e.fcnt = 0; e.fs = 1'b0; e.fe = 1'b0;
    return e;
  endfunction

  task automatic model_reset();
    m_armed = 0; m_live = 0; pv = 0; ph = 0;
    m_row = -1; m_col = 0; m_fcnt = 0; m_err = '0;
    for (int i = 0; i < NW; i++) begin
      sen[i] = 0; sx0[i] = 0; sx1[i] = 0; sy0[i] = 0; sy1[i] = 0;
    end
    e_prev = zero_exp();
  endtask

  task automatic model_step(input bit v, input bit h, output exp_t e);
    bit vr, vf, hr, ok;
    int yy;
    vr = m_live && v && !pv;
    vf = m_live && !v && pv;
    hr = h && !ph;
    e = zero_exp();
    e.fs = vr;
    e.fe = vf && m_armed;
    if (e.fe) m_fcnt = (m_fcnt + 1) % (1 << FW);
    if (vr) begin
      m_armed = 1;
      for (int i = 0; i < NW; i++) begin
        sen[i] = win_en[i];
        sx0[i] = win_x0[i*CW +: CW]; sx1[i] = win_x1[i*CW +: CW];
        sy0[i] = win_y0[i*CW +: CW]; sy1[i] = win_y1[i*CW +: CW];
        m_err[i] = (sx1[i] < sx0[i]) || (sy1[i] < sy0[i]);
      end
      m_row = hr ? 0 : -1;
    end else if (m_armed && v && hr) begin
      m_row = (m_row < 0) ? 0 : ((m_row < MAXC) ? m_row + 1 : MAXC);
    end
    if (m_armed && h) m_col = hr ? 0 : ((m_col < MAXC) ? m_col + 1 : MAXC);
    else              m_col = 0;
    yy = (m_armed && v && m_row > 0) ? m_row : 0;
    e.x = m_col;
    e.y = yy;
    for (int i = 0; i < NW; i++) begin
      ok = sen[i] != 0 && !m_err[i];
      e.href[i] = m_armed && h && ok && m_col >= sx0[i] && m_col <= sx1[i];
      e.vref[i] = m_armed && v && ok && yy >= sy0[i] && yy <= sy1[i];
    end
    e.act  = e.href & e.vref;
    e.err  = m_err;
    e.fcnt = m_fcnt;
    pv = v; ph = h; m_live = 1;
  endtask

  task automatic check_outs(input string p, input logic [NW-1:0] href, vref, act, err,
                            input logic [CW-1:0] x, y, input logic fs, fe,
                            input logic [FW-1:0] fc, input exp_t e);
    check({p, "href"}, 32'(href), 32'(e.href));
    check({p, "vref"}, 32'(vref), 32'(e.vref));
    check({p, "act"},  32'(act),  32'(e.act));
    check({p, "cfg_err"}, 32'(err), 32'(e.err));
    check({p, "pix_x"},  32'(x), e.x);
    check({p, "line_y"}, 32'(y), e.y);
    check({p, "frame_start"}, 32'(fs), 32'(e.fs));
    check({p, "frame_end"},   32'(fe), 32'(e.fe));
    check({p, "frame_cnt"},   32'(fc), e.fcnt);
  endtask

  task automatic cyc(input bit v, input bit h);
    exp_t e;
    vsync = v;
    hsync = h;
    @(posedge clk);
    #1;
    check_outs("a_", a_href, a_vref, a_act, a_err, a_x, a_y, a_fs, a_fe, a_fc, e_prev);
    check_outs("b_", b_href, b_vref, b_act, b_err, b_x, b_y, b_fs, b_fe, b_fc, e_prev);
    act0 += int'(a_act[0]);
    act1 += int'(a_act[1]);
    fs_b += int'(b_fs);
    fe_b += int'(b_fe);
    model_step(v, h, e);
    check("a_armed", 32'(a_armed), 32'(m_armed));
    check("b_armed", 32'(b_armed), 32'(m_armed));
    e_prev = e;
  endtask

  task automatic do_reset();
    exp_t z;
    z = zero_exp();
    rst_n = 1'b0;
    #1;
    check_outs("rst_a_", a_href, a_vref, a_act, a_err, a_x, a_y, a_fs, a_fe, a_fc, z);
    check_outs("rst_b_", b_href, b_vref, b_act, b_err, b_x, b_y, b_fs, b_fe, b_fc, z);
    check("rst_armed", 32'({a_armed, b_armed}), 32'(0));
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic frame(input int w, input int h, input int hbl, input int lead,
                       input int wr_row, input int rst_row, input bit noisy);
    for (int i = 0; i < 4; i++) cyc(1'b0, noisy ? 1'($urandom_range(0, 1)) : 1'b0);
    act0 = 0; act1 = 0;
    for (int i = 0; i < lead; i++) cyc(1'b1, 1'b0);
    for (int r = 0; r < h; r++) begin
      if (r == wr_row) begin
        win_en = alt_en; win_x0 = alt_x0; win_x1 = alt_x1; win_y0 = alt_y0; win_y1 = alt_y1;
      end
      for (int c = 0; c < w; c++) begin
        if (r == rst_row && c == 3) do_reset();
        cyc(1'b1, 1'b1);
      end
      for (int b = 0; b < hbl; b++) cyc(1'b1, 1'b0);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic set_win(input int i, input bit en, input int x0, x1, y0, y1);
    win_en[i] = en;
    win_x0[i*CW +: CW] = CW'(x0); win_x1[i*CW +: CW] = CW'(x1);
    win_y0[i*CW +: CW] = CW'(y0); win_y1[i*CW +: CW] = CW'(y1);
  endtask

  task automatic rand_cfg(input int w, input int h);
    for (int i = 0; i < NW; i++)
      set_win(i, $urandom_range(0, 3) != 0, $urandom_range(0, w), $urandom_range(0, w),
              $urandom_range(0, h), $urandom_range(0, h));
  endtask

  initial begin
    model_reset();
    do_reset();

    // Sync activity before arming is ignored.
    set_win(0, 1'b1, 0, 7, 0, 5);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'($urandom_range(0, 1)));
    check("prearm_armed", 32'(a_armed), 32'(0));
    check("prearm_fcnt", 32'(a_fc), 32'(0));

    // 8x6 frame, win0 x=[2,5] y=[1,3]; win1 inverted x bounds.
    set_win(0, 1'b1, 2, 5, 1, 3);
    set_win(1, 1'b1, 6, 3, 0, 5);
    frame(8, 6, 2, 0, -1, -1, 1'b0);
    check("win0_act_cycles", 32'(act0), 32'(12));
    check("win1_act_cycles", 32'(act1), 32'(0));
    check("cfg_err_vec", 32'(a_err), 32'(2'b10));

    // Mid-frame write only lands at the next frame start.
    alt_en = win_en; alt_x0 = win_x0; alt_x1 = win_x1; alt_y0 = win_y0; alt_y1 = win_y1;
    alt_x0[0 +: CW] = CW'(0);
    alt_x1[0 +: CW] = CW'(7);
    frame(8, 6, 2, 1, 2, -1, 1'b0);
    check("midwrite_same_frame", 32'(act0), 32'(12));
    frame(8, 6, 1, 0, -1, -1, 1'b0);
    check("midwrite_next_frame", 32'(act0), 32'(24));

    // Three frames from reset: pulse and frame counts on the active-low instance.
    do_reset();
    fs_b = 0; fe_b = 0;
    for (int f = 0; f < 3; f++) frame(8, 6, 2, 0, -1, -1, 1'b0);
    check("pol0_frame_starts", 32'(fs_b), 32'(3));
    check("pol0_frame_ends", 32'(fe_b), 32'(3));
    check("pol0_frame_cnt", 32'(b_fc), 32'(3));

    // Reset at row 2, then a clean frame restarts from origin.
    frame(8, 6, 2, 0, -1, 2, 1'b0);
    frame(8, 6, 2, 0, -1, -1, 1'b0);
    check("post_reset_frame", 32'(act0), 32'(24));
    check("post_reset_fcnt", 32'(a_fc), 32'(1));

    // Randomized frames with random windows, mid-frame writes and resets.
    for (int f = 0; f < 40; f++) begin
      int w, h;
      w = $urandom_range(4, 20);
      h = $urandom_range(3, 10);
      rand_cfg(w, h);
      alt_en = win_en; alt_x0 = win_x0; alt_x1 = win_x1; alt_y0 = win_y0; alt_y1 = win_y1;
      rand_cfg(w, h);
      {alt_en, win_en} = {win_en, alt_en};
      {alt_x0, win_x0} = {win_x0, alt_x0};
      {alt_x1, win_x1} = {win_x1, alt_x1};
      {alt_y0, win_y0} = {win_y0, alt_y0};
      {alt_y1, win_y1} = {win_y1, alt_y1};
      frame(w, h, $urandom_range(1, 3), $urandom_range(0, 2), $urandom_range(0, h + 2),
            ($urandom_range(0, 7) == 0) ? $urandom_range(0, h - 1) : -1, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
